imem_loader: RTL
================

Name: imem_loader

Overview:
- Boot-time writer for the instruction memory. The core only reads this memory.
- Accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit instructions.
- Writes each instruction into the imem write port and holds the core in reset until the program is fully loaded.
- Sits between the host link (UART RX or testbench) and imem / riscv reset.

Parameters:
- N_WORDS, 20, instruction memory depth in 32-bit words (same value as the imem depth parameter n).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- byte_data_i  input  8  incoming stream byte.
- byte_valid_i  input  1  byte_data_i is valid.
- byte_ready_o  output  1  loader accepts a byte this cycle.
- imem_we_o  output  1  imem write strobe, one cycle per word.
- imem_addr_o  output  32  imem byte address (word_index*4).
- imem_wdata_o  output  32  instruction word to write.
- core_rst_o  output  1  reset to the riscv core, active-high.
- done_o  output  1  load completed successfully (sticky).
- err_o  output  1  load aborted (sticky).

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high. All state updates on rising clk.
- Handshake: a byte transfers on a rising edge where byte_valid_i && byte_ready_o. The sender holds the byte while ready=0. byte_ready_o is decoded from state only, with no combinational path from valid.
- Stream format, in order:
  - LEN low byte, then LEN high byte: 16-bit word count.
  - LEN*4 data bytes. Within each word, the first byte goes to [7:0] and the last to [31:24].
- States:
  - LEN_LO: ready=1. On transfer, store low byte -> LEN_HI.
  - LEN_HI: ready=1. On transfer, form LEN.
    - LEN==0 -> DONE.
    - LEN>N_WORDS -> ERR.
    - Otherwise -> DATA, with byte_cnt=0 and word_idx=0.
  - DATA: ready=1. On transfer, shift the byte into the assembly register and increment byte_cnt (2 bits). On the 4th byte (byte_cnt==3) -> WRITE.
  - WRITE: ready=0, imem_we_o=1 for exactly this one cycle.
    - imem_addr_o = word_idx*4; imem_wdata_o = assembled word.
    - Next: word_idx+1. If word_idx+1==LEN -> DONE (or CKSUM, see Optional Feature); else -> DATA.
  - DONE: ready=0, core_rst_o=0, done_o=1. Stays here until rst.
  - ERR: ready=1 (bytes are drained and discarded), core_rst_o=1, err_o=1. Stays here until rst.
- Latency: the imem write is the cycle after the 4th byte is accepted. Minimum word period is 5 cycles (4 transfers + 1 WRITE).
- core_rst_o: 1 in every state except DONE. It deasserts on the cycle after the last WRITE.
- Output values in the cycle after reset (state LEN_LO):
  - byte_ready_o=1, imem_we_o=0, imem_addr_o=0, imem_wdata_o=0.
  - core_rst_o=1, done_o=0, err_o=0.
- Output values while rst is high: outputs take the same values as above from the next edge on.
- Boundary conditions:
  - LEN==N_WORDS: legal; the last write goes to address (N_WORDS-1)*4.
  - LEN==N_WORDS+1: ERR, and no imem write ever occurs.
  - word_idx never wraps; it is bounded by the LEN check.
  - rst mid-load: partial word and counters are discarded, state returns to LEN_LO. Already-written imem contents are not cleared.
  - imem_addr_o and imem_wdata_o hold their last written values outside WRITE.
  - byte_valid_i during WRITE or DONE: ignored (ready=0).

Optional Feature:
- Macro: IMEM_LOADER_CKSUM_EN.
- Defined:
  - After the last WRITE, go to state CKSUM (ready=1) and accept one byte.
  - If that byte equals the XOR of all data bytes -> DONE; otherwise -> ERR.
  - The running XOR resets in LEN_HI, and on LEN==0 the checksum byte is still required (expected value 0x00).
- Undefined: no CKSUM state; after the last WRITE go directly to DONE.

Test Plan:
- Reset then stream 01 00 13 05 A0 00 -> one imem write, addr=0x0, wdata=0x00A00513. core_rst_o falls the cycle after the write and done_o=1.
- LEN=3 with bytes random per word and byte_valid_i toggled randomly -> exactly 3 writes at addrs 0x0, 0x4, 0x8 with correct words. No transfer occurs while ready=0.
- LEN=0x0015 (21 > 20) -> err_o=1, core_rst_o stays 1, imem_we_o never asserts, and the subsequent 8 bytes are accepted and discarded.
- LEN=20 full program -> last write at addr 0x4C, done_o=1. The next byte_valid_i is not accepted.
- rst asserted after 2 data bytes of word 1, then a new stream with LEN=1 and word 0xDEADBEEF -> single write of 0xDEADBEEF at addr 0x0. No stale bytes appear in the word.
- With IMEM_LOADER_CKSUM_EN: stream 01 00 13 05 A0 00 plus checksum byte 0xB6 -> done_o=1. The same stream with checksum 0xB7 -> err_o=1 and core_rst_o stays 1.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader: boot-time instruction memory writer.
// Takes a byte stream (LEN lo, LEN hi, then LEN*4 little-endian data bytes),
// assembles 32-bit words and writes each into the imem write port. The core
// is held in reset until the whole program has been written.
// Optional feature macro: IMEM_LOADER_CKSUM_EN adds a trailing XOR checksum
// byte that must match before the core is released.
//
// Handshake: a byte transfers on a rising clk edge where
// byte_valid_i && byte_ready_o. byte_ready_o depends on the state register
// only, so it never combinationally follows byte_valid_i; the sender holds
// byte_data_i stable while byte_ready_o is low.
module imem_loader #(
    parameter int N_WORDS = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  byte_data_i,
    input  logic        byte_valid_i,
    output logic        byte_ready_o,
    output logic        imem_we_o,
    output logic [31:0] imem_addr_o,
    output logic [31:0] imem_wdata_o,
    output logic        core_rst_o,
    output logic        done_o,
    output logic        err_o
);

    localparam logic [2:0] S_LEN_LO = 3'd0;
    localparam logic [2:0] S_LEN_HI = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_WRITE  = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;
    localparam logic [2:0] S_ERR    = 3'd5;
`ifdef IMEM_LOADER_CKSUM_EN
    localparam logic [2:0] S_CKSUM  = 3'd6;
`endif

    // Largest legal word count, widened to the LEN field width.
    localparam logic [15:0] MAX_LEN = 16'(N_WORDS);

    logic [2:0]  state;
    logic [7:0]  len_lo;
    logic [15:0] len;
    logic [1:0]  byte_cnt;
    logic [15:0] word_idx;
    logic [31:0] asm_word;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
`ifdef IMEM_LOADER_CKSUM_EN
    logic [7:0]  xor_acc;
`endif

    logic        xfer;
    logic [15:0] len_next;
    logic [15:0] idx_next;
    logic [31:0] word_next;
    logic [2:0]  end_state;

    // Handshake and next-value helpers shared by the state machine.
    always_comb begin
        xfer      = byte_valid_i && byte_ready_o;
        len_next  = {byte_data_i, len_lo};
        idx_next  = word_idx + 16'd1;
        // First byte of a word ends up in [7:0] after four right shifts.
        word_next = {byte_data_i, asm_word[31:8]};
`ifdef IMEM_LOADER_CKSUM_EN
        end_state = S_CKSUM;
`else
        end_state = S_DONE;
`endif
    end

    // Ready and status decode from the state register only.
    always_comb begin
        byte_ready_o = 1'b0;
        case (state)
            S_LEN_LO, S_LEN_HI, S_DATA, S_ERR: byte_ready_o = 1'b1;
`ifdef IMEM_LOADER_CKSUM_EN
            S_CKSUM:                           byte_ready_o = 1'b1;
`endif
            default:                           byte_ready_o = 1'b0;
        endcase
        imem_we_o    = (state == S_WRITE);
        core_rst_o   = (state != S_DONE);
        done_o       = (state == S_DONE);
        err_o        = (state == S_ERR);
        imem_addr_o  = addr_q;
        imem_wdata_o = wdata_q;
    end

    // Loader state machine: length capture, word assembly, write, terminal states.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_LEN_LO;
            len_lo   <= 8'd0;
            len      <= 16'd0;
            byte_cnt <= 2'd0;
            word_idx <= 16'd0;
            asm_word <= 32'd0;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
`ifdef IMEM_LOADER_CKSUM_EN
            xor_acc  <= 8'd0;
`endif
        end else begin
            case (state)
                S_LEN_LO: begin
                    if (xfer) begin
                        len_lo <= byte_data_i;
                        state  <= S_LEN_HI;
                    end
                end

                S_LEN_HI: begin
                    if (xfer) begin
                        len      <= len_next;
                        byte_cnt <= 2'd0;
                        word_idx <= 16'd0;
`ifdef IMEM_LOADER_CKSUM_EN
                        xor_acc  <= 8'd0;
`endif
                        if (len_next == 16'd0) begin
                            state <= end_state;
                        end else if (len_next > MAX_LEN) begin
                            // Oversized program: reject before any imem write.
                            state <= S_ERR;
                        end else begin
                            state <= S_DATA;
                        end
                    end
                end

                S_DATA: begin
                    if (xfer) begin
                        asm_word <= word_next;
                        byte_cnt <= byte_cnt + 2'd1;
`ifdef IMEM_LOADER_CKSUM_EN
                        xor_acc  <= xor_acc ^ byte_data_i;
`endif
                        if (byte_cnt == 2'd3) begin
                            // Address/data registers only change here, so they
                            // hold the last written values outside WRITE.
                            addr_q  <= {14'd0, word_idx, 2'b00};
                            wdata_q <= word_next;
                            state   <= S_WRITE;
                        end
                    end
                end

                S_WRITE: begin
                    word_idx <= idx_next;
                    if (idx_next == len) begin
                        state <= end_state;
                    end else begin
                        state <= S_DATA;
                    end
                end

`ifdef IMEM_LOADER_CKSUM_EN
                S_CKSUM: begin
                    if (xfer) begin
                        state <= (byte_data_i == xor_acc) ? S_DONE : S_ERR;
                    end
                end
`endif

                // Terminal states: DONE ignores the link, ERR drains it.
                S_DONE:  state <= S_DONE;
                S_ERR:   state <= S_ERR;
                default: state <= S_LEN_LO;
            endcase
        end
    end

endmodule
